// File: rtl/ctl_game_round.sv
// Game-flow controller for Duck Hunt: sequences ducks within a round and
// rounds within a game for one or two players. It tracks ammo, hits and BCD
// scores, and drives the duck spawn request, display digits and overlay flags.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | no game running, waiting for start
// WAIT       | counting new_frame pulses before the next launch
// FLY        | duck on screen, shots and hits are accepted
// DUCK_DONE  | one cycle: count the finished duck
// ROUND_END  | one cycle: pass/fail decision, player/round advance
// OVER       | game lost, outputs hold until start
module ctl_game_round #(
  parameter int AMMO_PER_DUCK       = 3,
  parameter int DUCKS_PER_ROUND     = 10,
  parameter int HITS_TO_PASS        = 6,
  parameter int LAUNCH_DELAY_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       pause,
  input  logic       p2_connected,
  input  logic       start,
  input  logic       shot_fired,
  input  logic       hit,
  input  logic       duck_escaped,
  output logic       duck_launch,
  output logic       duck_fly_away,
  output logic       active_player,
  output logic [3:0] ammo_bcd,
  output logic [7:0] score_p1_bcd,
  output logic [7:0] score_p2_bcd,
  output logic [7:0] round_bcd,
  output logic [3:0] hits_in_round,
  output logic       game_over,
  output logic       looser,
  output logic       looser_id
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FLY, S_DUCK_DONE, S_ROUND_END, S_OVER
  } state_t;

  localparam logic [3:0] AMMO_INIT  = 4'(AMMO_PER_DUCK);
  localparam logic [3:0] DUCK_LAST  = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0] HITS_PASS  = 4'(HITS_TO_PASS);
  localparam logic [7:0] DELAY_LAST = 8'(LAUNCH_DELAY_FRAMES - 1);

  state_t     state, state_nxt;
  logic       two_player;
  logic [7:0] delay_cnt;
  logic [3:0] duck_cnt;

  logic start_game, frame_tick, launch, fly_hit, fly_shot, fly_empty;
  logic duck_done, round_end, round_last, round_fail;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; pause freezes the FSM where it is.
  always_comb begin
    state_nxt = state;
    if (!pause) begin
      case (state)
        S_IDLE:      if (start) state_nxt = S_WAIT;
        S_WAIT:      if (new_frame && delay_cnt == DELAY_LAST) state_nxt = S_FLY;
        S_FLY:       if (hit || duck_escaped) state_nxt = S_DUCK_DONE;
        S_DUCK_DONE: state_nxt = (duck_cnt == DUCK_LAST) ? S_ROUND_END : S_WAIT;
        S_ROUND_END: state_nxt = (hits_in_round < HITS_PASS) ? S_OVER : S_WAIT;
        S_OVER:      if (start) state_nxt = S_WAIT;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // Per-state datapath strobes; every strobe is gated off while paused so
  // input pulses during pause are dropped rather than deferred.
  always_comb begin
    start_game = !pause && start && (state == S_IDLE || state == S_OVER);
    frame_tick = !pause && new_frame && state == S_WAIT;
    launch     = frame_tick && delay_cnt == DELAY_LAST;
    fly_hit    = !pause && hit && state == S_FLY;
    fly_shot   = !pause && shot_fired && state == S_FLY && ammo_bcd != 4'd0;
    // A hit on the last shot wins: the duck is done, no fly-away.
    fly_empty  = fly_shot && ammo_bcd == 4'd1 && !hit;
    duck_done  = !pause && state == S_DUCK_DONE;
    round_end  = !pause && state == S_ROUND_END;
    round_last = duck_cnt == DUCK_LAST;
    round_fail = hits_in_round < HITS_PASS;
  end

  // Counters, scores and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      duck_launch   <= 1'b0;
      duck_fly_away <= 1'b0;
      active_player <= 1'b0;
      two_player    <= 1'b0;
      ammo_bcd      <= AMMO_INIT;
      score_p1_bcd  <= 8'h00;
      score_p2_bcd  <= 8'h00;
      round_bcd     <= 8'h01;
      hits_in_round <= 4'd0;
      duck_cnt      <= 4'd0;
      delay_cnt     <= 8'd0;
      game_over     <= 1'b0;
      looser        <= 1'b0;
      looser_id     <= 1'b0;
    end else begin
      duck_launch   <= launch;
      duck_fly_away <= fly_empty;

      if (start_game) begin
        score_p1_bcd  <= 8'h00;
        score_p2_bcd  <= 8'h00;
        round_bcd     <= 8'h01;
        two_player    <= p2_connected;
        active_player <= 1'b0;
        ammo_bcd      <= AMMO_INIT;
        hits_in_round <= 4'd0;
        duck_cnt      <= 4'd0;
        delay_cnt     <= 8'd0;
        game_over     <= 1'b0;
        looser        <= 1'b0;
        looser_id     <= 1'b0;
      end

      if (frame_tick)
        delay_cnt <= launch ? 8'd0 : delay_cnt + 8'd1;

      if (launch)
        ammo_bcd <= AMMO_INIT;

      if (fly_shot)
        ammo_bcd <= ammo_bcd - 4'd1;

      if (fly_hit) begin
        hits_in_round <= hits_in_round + 4'd1;
        if (active_player)
          score_p2_bcd <= bcd_inc(score_p2_bcd);
        else
          score_p1_bcd <= bcd_inc(score_p1_bcd);
      end

      if (duck_done) begin
        duck_cnt  <= duck_cnt + 4'd1;
        delay_cnt <= 8'd0;
      end

      if (round_end) begin
        if (round_fail) begin
          game_over <= 1'b1;
          looser    <= 1'b1;
          looser_id <= active_player;
        end else begin
          hits_in_round <= 4'd0;
          duck_cnt      <= 4'd0;
          delay_cnt     <= 8'd0;
          if (two_player && !active_player) begin
            active_player <= 1'b1;
          end else begin
            active_player <= 1'b0;
            round_bcd     <= bcd_inc(round_bcd);
          end
        end
      end
    end
  end

  // round_last is informational for the DUCK_DONE decision already made in
  // the next-state logic; fold it here so both views stay consistent.
  logic unused_ok;
  assign unused_ok = round_last;

endmodule

// File: tb/tb_ctl_game_round.sv
// Directed bench for ctl_game_round with default parameters
// (3 shots, 10 ducks, 6 hits to pass, 60-frame launch delay).
module tb_ctl_game_round;

  logic       clk = 1'b0;
  logic       rst, new_frame, pause, p2_connected, start;
  logic       shot_fired, hit, duck_escaped;
  logic       duck_launch, duck_fly_away, active_player;
  logic [3:0] ammo_bcd, hits_in_round;
  logic [7:0] score_p1_bcd, score_p2_bcd, round_bcd;
  logic       game_over, looser, looser_id;

  int n_checks = 0;
  int n_errors = 0;
  int l;

  ctl_game_round dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .pause(pause),
    .p2_connected(p2_connected), .start(start), .shot_fired(shot_fired),
    .hit(hit), .duck_escaped(duck_escaped), .duck_launch(duck_launch),
    .duck_fly_away(duck_fly_away), .active_player(active_player),
    .ammo_bcd(ammo_bcd), .score_p1_bcd(score_p1_bcd),
    .score_p2_bcd(score_p2_bcd), .round_bcd(round_bcd),
    .hits_in_round(hits_in_round), .game_over(game_over),
    .looser(looser), .looser_id(looser_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n new_frame pulses, one every other cycle; counts launch pulses seen.
  task automatic frames(input int n, output int launches);
    launches = 0;
    repeat (n) begin
      new_frame = 1'b1;
      @(negedge clk);
      if (duck_launch) launches++;
      new_frame = 1'b0;
      @(negedge clk);
      if (duck_launch) launches++;
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic e);
    shot_fired = s; hit = h; duck_escaped = e;
    @(negedge clk);
    shot_fired = 1'b0; hit = 1'b0; duck_escaped = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full duck: delay, then hit or escape, then DUCK_DONE and ROUND_END slots.
  task automatic duck(input logic got_hit);
    int nl;
    frames(60, nl);
    if (got_hit) drive(1'b1, 1'b1, 1'b0);
    else         drive(1'b0, 1'b0, 1'b1);
    cyc(2);
  endtask

  initial begin
    rst = 1'b1; new_frame = 1'b0; pause = 1'b0; p2_connected = 1'b0;
    start = 1'b0; shot_fired = 1'b0; hit = 1'b0; duck_escaped = 1'b0;
    cyc(2);
    check("rst_ammo",  8'(ammo_bcd), 8'h03);
    check("rst_p1",    score_p1_bcd, 8'h00);
    check("rst_p2",    score_p2_bcd, 8'h00);
    check("rst_round", round_bcd, 8'h01);
    check("rst_hits",  8'(hits_in_round), 8'h00);
    check("rst_over",  8'(game_over), 8'h00);
    check("rst_act",   8'(active_player), 8'h00);
    rst = 1'b0;
    cyc(1);
    frames(60, l);
    check("idle_no_launch", 8'(l), 8'd0);

    // ---- Game A: single player ----
    pulse_start();
    frames(60, l);
    check("first_launch", 8'(l), 8'd1);
    drive(1'b1, 1'b1, 1'b0);
    check("shot_hit_ammo", 8'(ammo_bcd), 8'h02);
    check("shot_hit_p1",   score_p1_bcd, 8'h01);
    check("shot_hit_hits", 8'(hits_in_round), 8'h01);
    cyc(2);

    frames(60, l);
    drive(1'b1, 1'b0, 1'b0);
    check("miss_ammo2", 8'(ammo_bcd), 8'h02);
    drive(1'b1, 1'b0, 1'b0);
    check("miss_ammo1", 8'(ammo_bcd), 8'h01);
    check("miss_no_fly", 8'(duck_fly_away), 8'h00);
    drive(1'b1, 1'b0, 1'b0);
    check("miss_ammo0", 8'(ammo_bcd), 8'h00);
    check("fly_away", 8'(duck_fly_away), 8'h01);
    drive(1'b1, 1'b0, 1'b0);
    check("fourth_shot_ammo", 8'(ammo_bcd), 8'h00);
    check("fly_away_once", 8'(duck_fly_away), 8'h00);
    drive(1'b0, 1'b0, 1'b1);
    cyc(2);
    check("escape_p1",   score_p1_bcd, 8'h01);
    check("escape_hits", 8'(hits_in_round), 8'h01);

    // Duck 3: pause during the launch delay.
    frames(30, l);
    check("delay_30", 8'(l), 8'd0);
    pause = 1'b1;
    frames(40, l);
    drive(1'b1, 1'b1, 1'b0);
    check("pause_no_launch", 8'(l), 8'd0);
    check("pause_hits", 8'(hits_in_round), 8'h01);
    pause = 1'b0;
    frames(29, l);
    check("resume_59", 8'(l), 8'd0);
    frames(1, l);
    check("resume_launch", 8'(l), 8'd1);
    drive(1'b1, 1'b1, 1'b0);
    cyc(2);
    check("duck3_p1", score_p1_bcd, 8'h02);

    // Duck 4: pause while flying.
    frames(60, l);
    pause = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    check("pause_fly_ammo", 8'(ammo_bcd), 8'h03);
    check("pause_fly_p1",   score_p1_bcd, 8'h02);
    drive(1'b0, 1'b0, 1'b1);
    cyc(1);
    pause = 1'b0;
    cyc(1);
    drive(1'b1, 1'b1, 1'b0);
    check("resume_fly_p1",   score_p1_bcd, 8'h03);
    check("resume_fly_ammo", 8'(ammo_bcd), 8'h02);
    cyc(2);

    repeat (3) duck(1'b1);
    repeat (3) duck(1'b0);
    check("r1_round", round_bcd, 8'h02);
    check("r1_hits",  8'(hits_in_round), 8'h00);
    check("r1_over",  8'(game_over), 8'h00);
    check("r1_p1",    score_p1_bcd, 8'h06);

    repeat (5) duck(1'b1);
    repeat (5) duck(1'b0);
    check("r2_over",   8'(game_over), 8'h01);
    check("r2_looser", 8'(looser), 8'h01);
    check("r2_lid",    8'(looser_id), 8'h00);
    check("r2_p1",     score_p1_bcd, 8'h11);
    frames(60, l);
    check("over_hold", 8'(l), 8'd0);

    // ---- Game B: two players, restart from OVER ----
    p2_connected = 1'b1;
    pulse_start();
    p2_connected = 1'b0;
    check("b_over",  8'(game_over), 8'h00);
    check("b_p1",    score_p1_bcd, 8'h00);
    check("b_round", round_bcd, 8'h01);
    repeat (10) duck(1'b1);
    check("b_p1pass_act",   8'(active_player), 8'h01);
    check("b_p1pass_round", round_bcd, 8'h01);
    check("b_p1pass_p1",    score_p1_bcd, 8'h10);
    repeat (6) duck(1'b1);
    repeat (4) duck(1'b0);
    check("b_p2pass_act",   8'(active_player), 8'h00);
    check("b_p2pass_round", round_bcd, 8'h02);
    check("b_p2pass_p2",    score_p2_bcd, 8'h06);
    repeat (6) duck(1'b1);
    repeat (4) duck(1'b0);
    check("b_r2p1_act", 8'(active_player), 8'h01);
    repeat (5) duck(1'b1);
    repeat (5) duck(1'b0);
    check("b_p2fail_over", 8'(game_over), 8'h01);
    check("b_p2fail_lid",  8'(looser_id), 8'h01);
    check("b_p2fail_p2",   score_p2_bcd, 8'h11);

    // ---- Game C: score saturation, then reset mid-flight ----
    pulse_start();
    check("c_p2",  score_p2_bcd, 8'h00);
    check("c_act", 8'(active_player), 8'h00);
    repeat (90) duck(1'b1);
    check("c_r9_round", round_bcd, 8'h10);
    check("c_r9_p1",    score_p1_bcd, 8'h90);
    repeat (9) duck(1'b1);
    check("c_99", score_p1_bcd, 8'h99);
    duck(1'b1);
    check("c_sat",   score_p1_bcd, 8'h99);
    check("c_round", round_bcd, 8'h11);

    frames(60, l);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("pre_rst_ammo", 8'(ammo_bcd), 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ammo",  8'(ammo_bcd), 8'h03);
    check("mid_rst_p1",    score_p1_bcd, 8'h00);
    check("mid_rst_round", round_bcd, 8'h01);
    check("mid_rst_launch", 8'(duck_launch), 8'h00);
    check("mid_rst_fly",   8'(duck_fly_away), 8'h00);
    frames(60, l);
    check("mid_rst_idle", 8'(l), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
